vn_ib_ram_loader: RTL and testbench

//  Multi-channel IB-RAM page loader for the VN write path.
//  - On request, streams one iteration's page set (PAGE_NUM words) from the IB-ROMs into the VN IB-RAMs
//    for CH_NUM channels in lock-step.
//  - Handles ROM read latency, tracks the Iter0_24/Iter25_49 group switch, and supports abort.
//  - Sits between the Iteration Update Control Unit and the VN IB-RAM write ports.

---
 rtl/vn_ib_ram_loader_if.sv | 49 ++++
 rtl/vn_ib_ram_loader.sv | 146 ++++++++++++++
 tb/tb_vn_ib_ram_loader.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vn_ib_ram_loader_if.sv
// vn_ib_ram_loader_if
//   Bundles the load-control, ROM read and RAM write signals of the VN
//   IB-RAM page loader.
//
//   Request/response handshake: load_start is a one-cycle request that is
//   accepted only when load_busy is low. load_busy acts as the inverse of
//   ready. An accepted request produces either one load_done pulse, or a
//   silent return to idle on load_abort. A request with load_iter out of
//   range is dropped and answered by one load_err pulse.
//
//   Modports:
//     master : request side; also drives rom_dout as the ROM model/bank.
//     slave  : the loader itself.
//   dbg_state exposes the loader FSM state (0 = IDLE, 1 = FETCH,
//   2 = DRAIN, 3 = DONE).
interface vn_ib_ram_loader_if #(
  parameter int CH_NUM       = 2,
  parameter int ROM_RD_BW    = 8,
  parameter int ROM_ADDR_BW  = 11,
  parameter int PAGE_ADDR_BW = 6,
  parameter int ITER_ADDR_BW = 5
);
  logic                           load_start;
  logic [ITER_ADDR_BW-1:0]        load_iter;
  logic                           load_abort;
  logic                           load_busy;
  logic                           load_done;
  logic                           load_err;
  logic                           iter_switch;
  logic                           rom_rd_en;
  logic [ROM_ADDR_BW-1:0]         rom_read_addr;
  logic [CH_NUM*ROM_RD_BW-1:0]    rom_dout;
  logic                           ram_we;
  logic [PAGE_ADDR_BW-1:0]        ram_waddr;
  logic [CH_NUM*ROM_RD_BW-1:0]    ram_din;
  logic [1:0]                     dbg_state;

  modport master (
    output load_start, load_iter, load_abort, rom_dout,
    input  load_busy, load_done, load_err, iter_switch, rom_rd_en,
           rom_read_addr, ram_we, ram_waddr, ram_din, dbg_state
  );

  modport slave (
    input  load_start, load_iter, load_abort, rom_dout,
    output load_busy, load_done, load_err, iter_switch, rom_rd_en,
           rom_read_addr, ram_we, ram_waddr, ram_din, dbg_state
  );
endinterface

// File: rtl/vn_ib_ram_loader.sv
// vn_ib_ram_loader
//   Streams one iteration's page set (PAGE_NUM words) from the IB-ROMs into
//   the VN IB-RAMs for CH_NUM channels in lock-step. The module absorbs the
//   ROM read latency, tracks the Iter0_24 / Iter25_49 group switch and
//   supports abort.
//
// Ports
//   write_clk : clock, rising edge
//   rstn      : asynchronous active-low reset
//   bus       : vn_ib_ram_loader_if.slave
//               (load control, ROM read port, RAM write port, dbg_state)
module vn_ib_ram_loader #(
  parameter int CH_NUM       = 2,
  parameter int ROM_RD_BW    = 8,
  parameter int ROM_ADDR_BW  = 11,
  parameter int PAGE_ADDR_BW = 6,
  parameter int ITER_ADDR_BW = 5,
  parameter int PAGE_NUM     = 64,
  parameter int ITER_MAX     = 25,
  parameter int ROM_LATENCY  = 1
) (
  input logic               write_clk,
  input logic               rstn,
  vn_ib_ram_loader_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [31:0]             LP_ITER_MAX  = 32'(ITER_MAX);
  localparam logic [ITER_ADDR_BW-1:0] LP_ITER_LAST = ITER_ADDR_BW'(ITER_MAX - 1);
  localparam logic [PAGE_ADDR_BW-1:0] LP_PAGE_LAST = PAGE_ADDR_BW'(PAGE_NUM - 1);

  state_t                       r_state;
  state_t                       w_next;
  logic [ITER_ADDR_BW-1:0]      r_iter;
  logic [ROM_ADDR_BW-1:0]       r_addr;
  logic [PAGE_ADDR_BW-1:0]      r_page;
  logic [ROM_LATENCY-1:0]       r_vld;
  logic [PAGE_ADDR_BW-1:0]      r_pa [ROM_LATENCY];
  logic                         r_we;
  logic [PAGE_ADDR_BW-1:0]      r_waddr;
  logic [CH_NUM*ROM_RD_BW-1:0]  r_din;
  logic                         r_err;
  logic                         r_sw;

  logic w_kill;
  logic w_iter_ok;
  logic w_accept;
  logic w_last_page;
  logic w_rd_en;

  // Abort only has meaning while a load is in flight; in IDLE it just
  // suppresses a same-cycle request.
  assign w_kill      = bus.load_abort && (r_state != S_IDLE);
  assign w_iter_ok   = (32'(bus.load_iter) < LP_ITER_MAX);
  assign w_accept    = (r_state == S_IDLE) && bus.load_start && !bus.load_abort && w_iter_ok;
  assign w_last_page = (r_page == LP_PAGE_LAST);
  assign w_rd_en     = (r_state == S_FETCH);

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_kill) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_accept)    w_next = S_FETCH;
        S_FETCH: if (w_last_page) w_next = S_DRAIN;
        // Empty valid pipe means the last RAM write is on the bus this cycle.
        S_DRAIN: if (r_vld == '0) w_next = S_DONE;
        S_DONE:  w_next = S_IDLE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge write_clk or negedge rstn) begin
    if (!rstn) begin
      r_iter  <= '0;
      r_addr  <= '0;
      r_page  <= '0;
      r_vld   <= '0;
      for (int i = 0; i < ROM_LATENCY; i++) r_pa[i] <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_din   <= '0;
      r_err   <= 1'b0;
      r_sw    <= 1'b0;
    end else begin
      r_err <= (r_state == S_IDLE) && bus.load_start && !bus.load_abort && !w_iter_ok;

      if (w_accept) begin
        r_iter <= bus.load_iter;
        r_addr <= ROM_ADDR_BW'({bus.load_iter, {PAGE_ADDR_BW{1'b0}}});
        r_page <= '0;
      end else if (w_rd_en && !w_kill && !w_last_page) begin
        // Counters stop on the last page so the address never runs into
        // the next iteration's field.
        r_addr <= r_addr + ROM_ADDR_BW'(1);
        r_page <= r_page + PAGE_ADDR_BW'(1);
      end

      // Valid/page-address shift register mirrors the ROM read latency.
      if (w_kill) begin
        r_vld <= '0;
        r_we  <= 1'b0;
      end else begin
        r_vld[0] <= w_rd_en;
        r_pa[0]  <= r_page;
        for (int i = 1; i < ROM_LATENCY; i++) begin
          r_vld[i] <= r_vld[i-1];
          r_pa[i]  <= r_pa[i-1];
        end
        r_we <= r_vld[ROM_LATENCY-1];
        if (r_vld[ROM_LATENCY-1]) begin
          r_din   <= bus.rom_dout;
          r_waddr <= r_pa[ROM_LATENCY-1];
        end
      end

      // The last iteration of a group hands over to the other ROM group.
      if ((r_state == S_DONE) && !w_kill && (r_iter == LP_ITER_LAST)) r_sw <= ~r_sw;
    end
  end

  assign bus.load_busy     = (r_state != S_IDLE);
  assign bus.load_done     = (r_state == S_DONE);
  assign bus.load_err      = r_err;
  assign bus.iter_switch   = r_sw;
  assign bus.rom_rd_en     = w_rd_en;
  assign bus.rom_read_addr = r_addr;
  assign bus.ram_we        = r_we;
  assign bus.ram_waddr     = r_waddr;
  assign bus.ram_din       = r_din;
  assign bus.dbg_state     = r_state;

endmodule

// File: tb/tb_vn_ib_ram_loader.sv
// tb_vn_ib_ram_loader
//   Bench for vn_ib_ram_loader. Instance A uses the default parameters;
//   instance B uses ROM_LATENCY=3, CH_NUM=4 and PAGE_NUM=10. The ROM
//   contents are a seeded function of (address, channel). Expected
//   behaviour is derived per cycle from the load timeline.
module tb_vn_ib_ram_loader;

  localparam int A_CH = 2, A_L = 1, A_P = 64;
  localparam int B_CH = 4, B_L = 3, B_P = 10;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  vn_ib_ram_loader_if #(.CH_NUM(A_CH)) a_if ();
  vn_ib_ram_loader_if #(.CH_NUM(B_CH)) b_if ();

  vn_ib_ram_loader #(.CH_NUM(A_CH), .ROM_LATENCY(A_L), .PAGE_NUM(A_P)) dut_a (
    .write_clk(clk), .rstn(rstn), .bus(a_if));
  vn_ib_ram_loader #(.CH_NUM(B_CH), .ROM_LATENCY(B_L), .PAGE_NUM(B_P)) dut_b (
    .write_clk(clk), .rstn(rstn), .bus(b_if));

  int unsigned seed;
  int n_checks = 0;
  int n_fail = 0;
  bit sw_a = 1'b0;
  bit sw_b = 1'b0;

  // Expected RAM write data, oldest first, for the current load.
  logic [31:0] exp_q[$];

  function automatic logic [7:0] rom_word(input int addr, input int ch);
    logic [31:0] h;
    h = 32'(addr) * 32'd13 + 32'(ch) * 32'd71 + seed;
    return h[7:0] ^ h[15:8];
  endfunction

  // ROM models: A has latency 1, B has latency 3; outputs hold between reads.
  always @(posedge clk) begin
    if (a_if.rom_rd_en)
      for (int ch = 0; ch < A_CH; ch++)
        a_if.rom_dout[ch*8 +: 8] <= rom_word(int'(a_if.rom_read_addr), ch);
  end

  logic [31:0] b_p0, b_p1;
  always @(posedge clk) begin
    if (b_if.rom_rd_en)
      for (int ch = 0; ch < B_CH; ch++)
        b_p0[ch*8 +: 8] <= rom_word(int'(b_if.rom_read_addr), ch);
    b_p1 <= b_p0;
    b_if.rom_dout <= b_p1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drv(input bit sel, input bit st, input int it, input bit ab);
    if (sel) begin
      b_if.load_start = st; b_if.load_iter = 5'(it); b_if.load_abort = ab;
    end else begin
      a_if.load_start = st; a_if.load_iter = 5'(it); a_if.load_abort = ab;
    end
  endtask

  // One load request at cycle 0, checked every cycle until idle again.
  // abort_c > 0 aborts during that cycle; extra_c > 0 fires an extra
  // load_start (iter 24) in that cycle, which must be ignored.
  task automatic run_load(input bit sel, input int iter, input int abort_c, input int extra_c);
    int P, L, CH, dones, page;
    bit live, exp_rd, exp_we, exp_done, exp_busy, have_last, sw_before;
    logic act_rd, act_we, act_done, act_busy, act_err, act_sw;
    logic [31:0] act_addr, act_waddr, act_din, exp_din, last_din;
    P  = sel ? B_P : A_P;
    L  = sel ? B_L : A_L;
    CH = sel ? B_CH : A_CH;
    dones = 0; have_last = 1'b0; last_din = '0;
    sw_before = sel ? sw_b : sw_a;
    exp_q.delete();
    for (int p = 0; p < P; p++) begin
      exp_din = '0;
      for (int ch = 0; ch < CH; ch++) exp_din[ch*8 +: 8] = rom_word(iter * 64 + p, ch);
      exp_q.push_back(exp_din);
    end
    @(negedge clk);
    drv(sel, 1'b1, iter, 1'b0);
    for (int c = 1; c <= P + L + 5; c++) begin
      @(negedge clk);
      drv(sel, (c == extra_c), (c == extra_c) ? 24 : iter, (c == abort_c));
      act_rd    = sel ? b_if.rom_rd_en   : a_if.rom_rd_en;
      act_we    = sel ? b_if.ram_we      : a_if.ram_we;
      act_done  = sel ? b_if.load_done   : a_if.load_done;
      act_busy  = sel ? b_if.load_busy   : a_if.load_busy;
      act_err   = sel ? b_if.load_err    : a_if.load_err;
      act_sw    = sel ? b_if.iter_switch : a_if.iter_switch;
      act_addr  = sel ? 32'(b_if.rom_read_addr) : 32'(a_if.rom_read_addr);
      act_waddr = sel ? 32'(b_if.ram_waddr)     : 32'(a_if.ram_waddr);
      act_din   = sel ? b_if.ram_din : {16'h0, a_if.ram_din};
      live      = (abort_c == 0) || (c <= abort_c);
      exp_rd    = live && (c <= P);
      exp_we    = live && (c >= L + 2) && (c <= P + L + 1);
      exp_done  = live && (c == P + L + 2);
      exp_busy  = live && (c <= P + L + 2);
      chk($sformatf("rd_en c%0d", c), 32'(act_rd), 32'(exp_rd));
      chk($sformatf("ram_we c%0d", c), 32'(act_we), 32'(exp_we));
      chk($sformatf("done c%0d", c), 32'(act_done), 32'(exp_done));
      chk($sformatf("busy c%0d", c), 32'(act_busy), 32'(exp_busy));
      chk($sformatf("err c%0d", c), 32'(act_err), 32'd0);
      if (exp_rd) chk($sformatf("rom_addr c%0d", c), act_addr, 32'(iter * 64 + c - 1));
      if (exp_we) begin
        page = c - L - 2;
        chk($sformatf("waddr c%0d", c), act_waddr, 32'(page));
        exp_din = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
        chk($sformatf("din c%0d", c), act_din, exp_din);
        last_din = exp_din; have_last = 1'b1;
      end
      if (c == P + L + 2) chk("switch at done", 32'(act_sw), 32'(sw_before));
      if (act_done === 1'b1) dones++;
    end
    drv(sel, 1'b0, 0, 1'b0);
    if (iter == 24 && abort_c == 0) begin
      if (sel) sw_b = ~sw_b; else sw_a = ~sw_a;
    end
    act_sw  = sel ? b_if.iter_switch : a_if.iter_switch;
    act_din = sel ? b_if.ram_din : {16'h0, a_if.ram_din};
    chk("switch after load", 32'(act_sw), 32'(sel ? sw_b : sw_a));
    chk("done count", 32'(dones), (abort_c == 0) ? 32'd1 : 32'd0);
    if (abort_c != 0 && have_last) chk("din held after abort", act_din, last_din);
  endtask

  task automatic err_case(input int iter);
    @(negedge clk); drv(1'b0, 1'b1, iter, 1'b0);
    @(negedge clk); drv(1'b0, 1'b0, 0, 1'b0);
    chk("err pulse", 32'(a_if.load_err), 32'd1);
    chk("err busy", 32'(a_if.load_busy), 32'd0);
    chk("err rd_en", 32'(a_if.rom_rd_en), 32'd0);
    @(negedge clk);
    chk("err cleared", 32'(a_if.load_err), 32'd0);
    chk("err busy2", 32'(a_if.load_busy), 32'd0);
    chk("err rd_en2", 32'(a_if.rom_rd_en), 32'd0);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, " a rd_en"}, 32'(a_if.rom_rd_en), 32'd0);
    chk({tag, " a busy"}, 32'(a_if.load_busy), 32'd0);
    chk({tag, " a done"}, 32'(a_if.load_done), 32'd0);
    chk({tag, " a err"}, 32'(a_if.load_err), 32'd0);
    chk({tag, " a switch"}, 32'(a_if.iter_switch), 32'd0);
    chk({tag, " a we"}, 32'(a_if.ram_we), 32'd0);
    chk({tag, " a addr"}, 32'(a_if.rom_read_addr), 32'd0);
    chk({tag, " a waddr"}, 32'(a_if.ram_waddr), 32'd0);
    chk({tag, " a din"}, 32'(a_if.ram_din), 32'd0);
    chk({tag, " a state"}, 32'(a_if.dbg_state), 32'd0);
    chk({tag, " b busy"}, 32'(b_if.load_busy), 32'd0);
    chk({tag, " b din"}, b_if.ram_din, 32'd0);
  endtask

  typedef struct {
    int iter;
    int abort_c;
    int extra_c;
    bit exp_err;
    bit exp_sw;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int it, ab;
    vecs[0] = '{iter: 3,  abort_c: 0,  extra_c: 0,  exp_err: 1'b0, exp_sw: 1'b0};
    vecs[1] = '{iter: 24, abort_c: 0,  extra_c: 0,  exp_err: 1'b0, exp_sw: 1'b1};
    vecs[2] = '{iter: 24, abort_c: 0,  extra_c: 0,  exp_err: 1'b0, exp_sw: 1'b0};
    vecs[3] = '{iter: 5,  abort_c: 0,  extra_c: 10, exp_err: 1'b0, exp_sw: 1'b0};
    vecs[4] = '{iter: 25, abort_c: 0,  extra_c: 0,  exp_err: 1'b1, exp_sw: 1'b0};
    vecs[5] = '{iter: 24, abort_c: 20, extra_c: 0,  exp_err: 1'b0, exp_sw: 1'b0};
    vecs[6] = '{iter: 24, abort_c: 0,  extra_c: 0,  exp_err: 1'b0, exp_sw: 1'b1};
    vecs[7] = '{iter: 31, abort_c: 0,  extra_c: 0,  exp_err: 1'b1, exp_sw: 1'b1};

    seed = $urandom;
    drv(1'b0, 1'b0, 0, 1'b0);
    drv(1'b1, 1'b0, 0, 1'b0);
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    reset_checks("reset");
    rstn = 1'b1;

    // Table-driven loads on the default instance.
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].exp_err) err_case(vecs[i].iter);
      else run_load(1'b0, vecs[i].iter, vecs[i].abort_c, vecs[i].extra_c);
      chk($sformatf("table switch %0d", i), 32'(a_if.iter_switch), 32'(vecs[i].exp_sw));
    end

    // Reset pulsed mid-load (iter_switch is 1 here and must clear).
    @(negedge clk); drv(1'b0, 1'b1, 24, 1'b0);
    for (int c = 1; c < 30; c++) begin
      @(negedge clk); drv(1'b0, 1'b0, 24, 1'b0);
    end
    @(negedge clk);
    chk("pre-reset rd_en", 32'(a_if.rom_rd_en), 32'd1);
    rstn = 1'b0;
    #1;
    reset_checks("mid reset");
    sw_a = 1'b0;
    @(negedge clk); rstn = 1'b1;
    run_load(1'b0, 11, 0, 0);

    // Abort and start in the same idle cycle: request dropped.
    @(negedge clk); drv(1'b0, 1'b1, 3, 1'b1);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); drv(1'b0, 1'b0, 0, 1'b0);
      chk($sformatf("abort+start busy c%0d", c), 32'(a_if.load_busy), 32'd0);
      chk($sformatf("abort+start rd_en c%0d", c), 32'(a_if.rom_rd_en), 32'd0);
      chk($sformatf("abort+start err c%0d", c), 32'(a_if.load_err), 32'd0);
    end

    // Randomized loads with optional abort.
    for (int r = 0; r < 5; r++) begin
      it = $urandom_range(0, 24);
      ab = ($urandom_range(0, 1) == 1) ? $urandom_range(1, A_P + A_L + 1) : 0;
      run_load(1'b0, it, ab, 0);
    end

    // Deeper ROM latency, four channels, short page set.
    run_load(1'b1, $urandom_range(0, 23), 0, 0);
    run_load(1'b1, 24, 0, 0);
    run_load(1'b1, 24, 6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
